// File: rtl/video_mode_ctrl.sv
// Video mode controller: drives one of four fixed timing sets into the sync generator and
// switches between them on request. The switch waits for a frame boundary and is applied under a timed generator reset.
module video_mode_ctrl #(
    parameter int X_BITS         = 12,
    parameter int Y_BITS         = 12,
    parameter int DEFAULT_MODE   = 0,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4194303
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [1:0]            req_mode,
    output logic                  req_ready,
    output logic                  done,
    output logic                  timeout,
    output logic [1:0]            cur_mode,
    input  logic                  vs_in,
    output logic                  vg_reset,
    output logic                  interlaced,
    output logic [4*X_BITS-1:0]   h_timing,
    output logic [4*Y_BITS-1:0]   v_timing_0,
    output logic [4*Y_BITS-1:0]   v_timing_1,
    output logic [X_BITS-1:0]     hv_offset_0,
    output logic [X_BITS-1:0]     hv_offset_1
);

    // One counter serves both the reset hold and the vsync timeout.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {BOOT, IDLE, WAIT_VS, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             vg_reset_reg, vg_reset_next;
    logic             req_ready_reg, req_ready_next;
    logic             done_reg, done_next;
    logic             timeout_reg, timeout_next;
    logic [1:0]       cur_mode_reg, cur_mode_next;
    logic [1:0]       pend_mode_reg, pend_mode_next;
    logic             vs_q;
    logic             vs_edge;

    assign vs_edge = vs_in & ~vs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= BOOT;
            cnt_reg       <= '0;
            vg_reset_reg  <= 1'b1;
            req_ready_reg <= 1'b0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
            cur_mode_reg  <= 2'(DEFAULT_MODE);
            pend_mode_reg <= 2'(DEFAULT_MODE);
            vs_q          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            vg_reset_reg  <= vg_reset_next;
            req_ready_reg <= req_ready_next;
            done_reg      <= done_next;
            timeout_reg   <= timeout_next;
            cur_mode_reg  <= cur_mode_next;
            pend_mode_reg <= pend_mode_next;
            vs_q          <= vs_in;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        vg_reset_next  = vg_reset_reg;
        req_ready_next = req_ready_reg;
        done_next      = 1'b0;
        timeout_next   = done_reg ? 1'b0 : timeout_reg;
        cur_mode_next  = cur_mode_reg;
        pend_mode_next = pend_mode_reg;
        case (state_reg)
            BOOT: begin
                if (cnt_reg == RST_LAST) begin
                    vg_reset_next  = 1'b0;
                    req_ready_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                // req_ready is low here only for the cycle after a same-mode request.
                if (!req_ready_reg) begin
                    req_ready_next = 1'b1;
                end else if (req_valid) begin
                    req_ready_next = 1'b0;
                    pend_mode_next = req_mode;
                    if (req_mode == cur_mode_reg) begin
                        done_next = 1'b1;
                    end else begin
                        cnt_next   = '0;
                        state_next = WAIT_VS;
                    end
                end
            end
            WAIT_VS: begin
                if (vs_edge || cnt_reg == TO_LAST) begin
                    timeout_next  = ~vs_edge;
                    vg_reset_next = 1'b1;
                    cur_mode_next = pend_mode_reg;
                    cnt_next      = '0;
                    state_next    = HOLD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == RST_LAST) begin
                    vg_reset_next  = 1'b0;
                    done_next      = 1'b1;
                    req_ready_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // Timing table, indexed by the mode currently in effect.
    always_comb begin
        h_timing    = {X_BITS'(800), X_BITS'(16), X_BITS'(48), X_BITS'(96)};
        v_timing_0  = {Y_BITS'(525), Y_BITS'(10), Y_BITS'(33), Y_BITS'(2)};
        v_timing_1  = {Y_BITS'(525), Y_BITS'(10), Y_BITS'(33), Y_BITS'(2)};
        hv_offset_0 = '0;
        hv_offset_1 = '0;
        interlaced  = 1'b0;
        case (cur_mode_reg)
            2'd1: begin
                h_timing   = {X_BITS'(1650), X_BITS'(110), X_BITS'(220), X_BITS'(40)};
                v_timing_0 = {Y_BITS'(750), Y_BITS'(5), Y_BITS'(20), Y_BITS'(5)};
                v_timing_1 = {Y_BITS'(750), Y_BITS'(5), Y_BITS'(20), Y_BITS'(5)};
            end
            2'd2: begin
                h_timing    = {X_BITS'(2200), X_BITS'(88), X_BITS'(148), X_BITS'(44)};
                v_timing_0  = {Y_BITS'(562), Y_BITS'(2), Y_BITS'(15), Y_BITS'(5)};
                v_timing_1  = {Y_BITS'(563), Y_BITS'(2), Y_BITS'(16), Y_BITS'(5)};
                hv_offset_1 = X_BITS'(1100);
                interlaced  = 1'b1;
            end
            2'd3: begin
                h_timing   = {X_BITS'(2200), X_BITS'(88), X_BITS'(148), X_BITS'(44)};
                v_timing_0 = {Y_BITS'(1125), Y_BITS'(4), Y_BITS'(36), Y_BITS'(5)};
                v_timing_1 = {Y_BITS'(1125), Y_BITS'(4), Y_BITS'(36), Y_BITS'(5)};
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_reg;
    assign done      = done_reg;
    assign timeout   = timeout_reg;
    assign cur_mode  = cur_mode_reg;
    assign vg_reset  = vg_reset_reg;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: boot, same-mode request, vsync switch, timeout switch,
// ignored requests while busy, and reset during a switch.
module tb_video_mode_ctrl;
    localparam int XB = 12;
    localparam int YB = 12;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic [1:0]      req_mode = 2'd0;
    logic            vs_in = 1'b0;
    logic            req_ready, done, timeout, vg_reset, interlaced;
    logic [1:0]      cur_mode;
    logic [4*XB-1:0] h_timing;
    logic [4*YB-1:0] v_timing_0, v_timing_1;
    logic [XB-1:0]   hv_offset_0, hv_offset_1;

    int checks = 0;
    int errors = 0;

    logic [4*XB-1:0] exp_h0 = {12'd800, 12'd16, 12'd48, 12'd96};
    logic [4*XB-1:0] exp_h1 = {12'd1650, 12'd110, 12'd220, 12'd40};
    logic [4*XB-1:0] exp_h2 = {12'd2200, 12'd88, 12'd148, 12'd44};
    logic [4*YB-1:0] exp_v21 = {12'd563, 12'd2, 12'd16, 12'd5};
    logic [4*YB-1:0] exp_v30 = {12'd1125, 12'd4, 12'd36, 12'd5};

    video_mode_ctrl #(
        .X_BITS(XB), .Y_BITS(YB), .DEFAULT_MODE(0), .RST_CYCLES(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_mode(req_mode),
        .req_ready(req_ready), .done(done), .timeout(timeout), .cur_mode(cur_mode),
        .vs_in(vs_in), .vg_reset(vg_reset), .interlaced(interlaced), .h_timing(h_timing),
        .v_timing_0(v_timing_0), .v_timing_1(v_timing_1),
        .hv_offset_0(hv_offset_0), .hv_offset_1(hv_offset_1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (vg_reset !== 1'b1) begin errors++; $display("FAIL rst_vg_reset got %b exp 1", vg_reset); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        checks++; if (done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rst_done_timeout got %b%b exp 00", done, timeout); end
        checks++; if (cur_mode !== 2'd0) begin errors++; $display("FAIL rst_cur_mode got %0d exp 0", cur_mode); end
        checks++; if (h_timing !== exp_h0) begin errors++; $display("FAIL rst_h_timing got %h exp %h", h_timing, exp_h0); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (vg_reset !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL boot_hold[%0d] vg_reset/req_ready got %b/%b exp 1/0", i, vg_reset, req_ready); end
        end
        tick();
        checks++; if (vg_reset !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL boot_end vg_reset/req_ready/done got %b/%b/%b exp 0/1/0", vg_reset, req_ready, done); end
        $display("txn boot: cur_mode=%0d vg_reset=%b req_ready=%b", cur_mode, vg_reset, req_ready);
    endtask

    task automatic test_same_mode();
        req_valid = 1'b1; req_mode = 2'd0;
        tick();
        req_valid = 1'b0;
        checks++; if (done !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL same_done done/req_ready got %b/%b exp 1/0", done, req_ready); end
        checks++; if (vg_reset !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL same_no_reset vg_reset/timeout got %b/%b exp 0/0", vg_reset, timeout); end
        tick();
        checks++; if (done !== 1'b0 || req_ready !== 1'b1 || vg_reset !== 1'b0 || cur_mode !== 2'd0) begin errors++; $display("FAIL same_after done/ready/vg/mode got %b/%b/%b/%0d exp 0/1/0/0", done, req_ready, vg_reset, cur_mode); end
        $display("txn same-mode req=0: cur_mode=%0d", cur_mode);
    endtask

    task automatic test_switch_vs();
        req_valid = 1'b1; req_mode = 2'd2;
        tick();
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0 || done !== 1'b0 || cur_mode !== 2'd0) begin errors++; $display("FAIL vs_accept ready/done/mode got %b/%b/%0d exp 0/0/0", req_ready, done, cur_mode); end
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++; if (vg_reset !== 1'b0 || cur_mode !== 2'd0) begin errors++; $display("FAIL vs_wait[%0d] vg/mode got %b/%0d exp 0/0", i, vg_reset, cur_mode); end
        end
        vs_in = 1'b1;
        tick();
        checks++; if (vg_reset !== 1'b1 || cur_mode !== 2'd2) begin errors++; $display("FAIL vs_hold vg/mode got %b/%0d exp 1/2", vg_reset, cur_mode); end
        checks++; if (interlaced !== 1'b1 || hv_offset_1 !== 12'd1100 || hv_offset_0 !== 12'd0) begin errors++; $display("FAIL vs_interlace il/hv1/hv0 got %b/%0d/%0d exp 1/1100/0", interlaced, hv_offset_1, hv_offset_0); end
        checks++; if (h_timing !== exp_h2 || v_timing_1 !== exp_v21) begin errors++; $display("FAIL vs_table h/v1 got %h/%h exp %h/%h", h_timing, v_timing_1, exp_h2, exp_v21); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (vg_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL vs_hold[%0d] vg/done got %b/%b exp 1/0", i, vg_reset, done); end
        end
        tick();
        checks++; if (done !== 1'b1 || timeout !== 1'b0 || vg_reset !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL vs_done done/to/vg/ready got %b/%b/%b/%b exp 1/0/0/1", done, timeout, vg_reset, req_ready); end
        vs_in = 1'b0;
        tick();
        checks++; if (done !== 1'b0 || cur_mode !== 2'd2) begin errors++; $display("FAIL vs_after done/mode got %b/%0d exp 0/2", done, cur_mode); end
        $display("txn switch req=2 by vsync: cur_mode=%0d interlaced=%b", cur_mode, interlaced);
    endtask

    task automatic test_timeout();
        req_valid = 1'b1; req_mode = 2'd1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        checks++; if (vg_reset !== 1'b0 || cur_mode !== 2'd2) begin errors++; $display("FAIL to_wait99 vg/mode got %b/%0d exp 0/2", vg_reset, cur_mode); end
        tick();
        checks++; if (vg_reset !== 1'b1 || cur_mode !== 2'd1 || timeout !== 1'b1) begin errors++; $display("FAIL to_hold vg/mode/to got %b/%0d/%b exp 1/1/1", vg_reset, cur_mode, timeout); end
        checks++; if (h_timing !== exp_h1 || interlaced !== 1'b0) begin errors++; $display("FAIL to_table h/il got %h/%b exp %h/0", h_timing, interlaced, exp_h1); end
        for (int i = 0; i < 3; i++) tick();
        tick();
        checks++; if (done !== 1'b1 || timeout !== 1'b1 || vg_reset !== 1'b0) begin errors++; $display("FAIL to_done done/to/vg got %b/%b/%b exp 1/1/0", done, timeout, vg_reset); end
        tick();
        checks++; if (done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_clear done/to got %b/%b exp 0/0", done, timeout); end
        $display("txn switch req=1 by timeout: cur_mode=%0d", cur_mode);
    endtask

    task automatic test_ignored();
        req_valid = 1'b1; req_mode = 2'd0;
        tick();
        req_mode = 2'd3;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (req_ready !== 1'b0 || cur_mode !== 2'd1) begin errors++; $display("FAIL ign_wait ready/mode got %b/%0d exp 0/1", req_ready, cur_mode); end
        vs_in = 1'b1;
        tick();
        checks++; if (cur_mode !== 2'd0 || vg_reset !== 1'b1) begin errors++; $display("FAIL ign_hold mode/vg got %0d/%b exp 0/1", cur_mode, vg_reset); end
        for (int i = 0; i < 3; i++) tick();
        req_valid = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || cur_mode !== 2'd0) begin errors++; $display("FAIL ign_done done/mode got %b/%0d exp 1/0", done, cur_mode); end
        vs_in = 1'b0;
        tick();
        tick();
        checks++; if (cur_mode !== 2'd0 || req_ready !== 1'b1 || vg_reset !== 1'b0) begin errors++; $display("FAIL ign_final mode/ready/vg got %0d/%b/%b exp 0/1/0", cur_mode, req_ready, vg_reset); end
        $display("txn switch req=0 with busy req=3 ignored: cur_mode=%0d", cur_mode);
    endtask

    task automatic test_reset_mid_hold();
        req_valid = 1'b1; req_mode = 2'd3;
        tick();
        req_valid = 1'b0;
        tick();
        vs_in = 1'b1;
        tick();
        checks++; if (cur_mode !== 2'd3 || vg_reset !== 1'b1 || v_timing_0 !== exp_v30) begin errors++; $display("FAIL mid_hold mode/vg/v0 got %0d/%b/%h exp 3/1/%h", cur_mode, vg_reset, v_timing_0, exp_v30); end
        tick();
        reset = 1'b1;
        vs_in = 1'b0;
        tick();
        checks++; if (cur_mode !== 2'd0 || vg_reset !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst mode/vg/ready/done got %0d/%b/%b/%b exp 0/1/0/0", cur_mode, vg_reset, req_ready, done); end
        checks++; if (h_timing !== exp_h0) begin errors++; $display("FAIL mid_rst_table got %h exp %h", h_timing, exp_h0); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (vg_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL reboot[%0d] vg/done got %b/%b exp 1/0", i, vg_reset, done); end
        end
        tick();
        checks++; if (vg_reset !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || cur_mode !== 2'd0) begin errors++; $display("FAIL reboot_end vg/ready/done/mode got %b/%b/%b/%0d exp 0/1/0/0", vg_reset, req_ready, done, cur_mode); end
        $display("txn reset during switch to 3: cur_mode=%0d", cur_mode);
    endtask

    initial begin
        test_reset();
        test_same_mode();
        test_switch_vs();
        test_timeout();
        test_ignored();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
